// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: InstMemory address/data, redirect request and the
// decode-side valid/ready queue head, plus queue occupancy and fault status.
interface inst_fetch_unit_if #(
   parameter int unsigned ADDR_WIDTH      = 64,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned QUEUE_DEPTH_POW = 2
);
   logic [ADDR_WIDTH-1:0]    imem_address_out;
   logic [DATA_WIDTH-1:0]    imem_data_in;
   logic                     redirect_valid_in;
   logic [ADDR_WIDTH-1:0]    redirect_pc_in;
   logic                     inst_valid_out;
   logic                     inst_ready_in;
   logic [DATA_WIDTH-1:0]    inst_out;
   logic [ADDR_WIDTH-1:0]    inst_pc_out;
   logic [QUEUE_DEPTH_POW:0] queue_count_out;
   logic                     fault_out;

   modport master (
      output imem_address_out,
      input  imem_data_in,
      input  redirect_valid_in,
      input  redirect_pc_in,
      output inst_valid_out,
      input  inst_ready_in,
      output inst_out,
      output inst_pc_out,
      output queue_count_out,
      output fault_out
   );

   modport slave (
      input  imem_address_out,
      output imem_data_in,
      output redirect_valid_in,
      output redirect_pc_in,
      input  inst_valid_out,
      output inst_ready_in,
      input  inst_out,
      input  inst_pc_out,
      input  queue_count_out,
      input  fault_out
   );
endinterface

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, captures InstMemory data into a small {pc, inst}
// queue for decode, flushes on redirect and halts on illegal PCs.
module inst_fetch_unit #(
   parameter int unsigned           ADDR_WIDTH      = 64,
   parameter int unsigned           DATA_WIDTH      = 32,
   parameter int unsigned           MEM_DEPTH_POW   = 10,
   parameter int unsigned           QUEUE_DEPTH_POW = 2,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   inst_fetch_unit_if.master    fetch_if
);

   localparam int unsigned           DEPTH     = 1 << QUEUE_DEPTH_POW;
   localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(4) << MEM_DEPTH_POW;

   typedef logic [QUEUE_DEPTH_POW:0]   count_t;
   typedef logic [QUEUE_DEPTH_POW-1:0] ptr_t;
   typedef enum logic {ST_RUN, ST_FAULT} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   count_t                 count_q, count_d;
   ptr_t                   wr_ptr_q, wr_ptr_d;
   ptr_t                   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0]  q_pc_q   [DEPTH];
   logic [DATA_WIDTH-1:0]  q_inst_q [DEPTH];

   logic                   pc_legal;
   logic                   head_valid;
   logic                   pop;
   logic                   space;
   logic                   push;
   logic                   flush;

   always_comb begin
      pc_legal   = (pc_q[1:0] == 2'b00) && (pc_q < MEM_BYTES);
      head_valid = (count_q != '0);
      pop        = head_valid & fetch_if.inst_ready_in;
      space      = (count_q < count_t'(DEPTH)) | pop;
   end

   // State register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (!fetch_if.redirect_valid_in && !pc_legal) begin
               state_d = ST_FAULT;
            end
         end
         ST_FAULT: begin
            if (fetch_if.redirect_valid_in) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Per-state actions: redirect wins over fault check, which wins over fetch
   always_comb begin
      flush = 1'b0;
      push  = 1'b0;
      pc_d  = pc_q;
      if (fetch_if.redirect_valid_in) begin
         flush = 1'b1;
         pc_d  = fetch_if.redirect_pc_in;
      end else if ((state_q == ST_RUN) && pc_legal && space) begin
         push = 1'b1;
         pc_d = pc_q + ADDR_WIDTH'(4);
      end
   end

   // A pop accepted during a flush is still a valid handshake; the flush just
   // discards whatever it would have left behind.
   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + count_t'(1);
            2'b01:   count_d = count_q - count_t'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pc_q     <= RESET_PC;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         pc_q     <= pc_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset; the head is masked to zero whenever empty
   always_ff @(posedge clk_in) begin
      if (push) begin
         q_pc_q[wr_ptr_q]   <= pc_q;
         q_inst_q[wr_ptr_q] <= fetch_if.imem_data_in;
      end
   end

   always_comb begin
      fetch_if.imem_address_out = pc_q;
      fetch_if.inst_valid_out   = head_valid;
      fetch_if.inst_out         = head_valid ? q_inst_q[rd_ptr_q] : '0;
      fetch_if.inst_pc_out      = head_valid ? q_pc_q[rd_ptr_q]   : '0;
      fetch_if.queue_count_out  = count_q;
      fetch_if.fault_out        = (state_q == ST_FAULT);
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a combinational InstMemory model
// whose word at byte address a is {16'hC0DE, a[17:2]}.
module tb_inst_fetch_unit;

   localparam int unsigned AW  = 64;
   localparam int unsigned DW  = 32;
   localparam int unsigned QDP = 2;

   logic clk_in;
   logic rst_n_in;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   inst_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .QUEUE_DEPTH_POW(QDP)) bus ();

   inst_fetch_unit #(
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW),
      .MEM_DEPTH_POW   (10),
      .QUEUE_DEPTH_POW (QDP),
      .RESET_PC        (64'h0)
   ) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .fetch_if (bus)
   );

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {16'hC0DE, a[17:2]};
   endfunction

   assign bus.imem_data_in = mem_word(bus.imem_address_out);

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset(input logic rdy);
      rst_n_in              = 1'b0;
      bus.redirect_valid_in = 1'b0;
      bus.inst_ready_in     = rdy;
      tick();
      tick();
      rst_n_in = 1'b1;
   endtask

   task automatic redirect_to(input logic [AW-1:0] target);
      bus.redirect_valid_in = 1'b1;
      bus.redirect_pc_in    = target;
      tick();
      bus.redirect_valid_in = 1'b0;
   endtask

   always @(negedge clk_in) begin
      if (rst_n_in) begin
         check("count_le_depth", 64'(bus.queue_count_out <= 3'd4), 64'd1);
         check("valid_eq_nonempty", 64'(bus.inst_valid_out), 64'(bus.queue_count_out != 0));
      end
   end

   initial begin
      rst_n_in              = 1'b0;
      bus.inst_ready_in     = 1'b1;
      bus.redirect_valid_in = 1'b0;
      bus.redirect_pc_in    = '0;
      tick();
      check("rst_valid", 64'(bus.inst_valid_out), 64'd0);
      check("rst_count", 64'(bus.queue_count_out), 64'd0);
      check("rst_fault", 64'(bus.fault_out), 64'd0);
      check("rst_inst", 64'(bus.inst_out), 64'd0);
      check("rst_inst_pc", bus.inst_pc_out, 64'd0);
      check("rst_addr", bus.imem_address_out, 64'd0);
      rst_n_in = 1'b1;

      // Streaming with decode always ready
      for (int i = 0; i < 4; i++) begin
         tick();
         check("stream_valid", 64'(bus.inst_valid_out), 64'd1);
         check("stream_pc", bus.inst_pc_out, 64'(4 * i));
         check("stream_inst", 64'(bus.inst_out), 64'(mem_word(64'(4 * i))));
      end

      // Back-pressure fills the queue, then full-queue push+pop each cycle
      do_reset(1'b0);
      repeat (8) tick();
      check("stall_count", 64'(bus.queue_count_out), 64'd4);
      check("stall_addr", bus.imem_address_out, 64'h10);
      bus.inst_ready_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check("drain_pc", bus.inst_pc_out, 64'(4 * i));
         check("drain_inst", 64'(bus.inst_out), 64'(mem_word(64'(4 * i))));
         check("full_count", 64'(bus.queue_count_out), 64'd4);
         tick();
      end

      // Redirect flushes a partially full queue
      do_reset(1'b0);
      repeat (3) tick();
      check("pre_redir_count", 64'(bus.queue_count_out), 64'd3);
      redirect_to(64'h200);
      check("flush_count", 64'(bus.queue_count_out), 64'd0);
      check("flush_valid", 64'(bus.inst_valid_out), 64'd0);
      check("flush_inst", 64'(bus.inst_out), 64'd0);
      check("redir_addr", bus.imem_address_out, 64'h200);
      tick();
      check("redir_valid", 64'(bus.inst_valid_out), 64'd1);
      check("redir_pc", bus.inst_pc_out, 64'h200);
      check("redir_inst", 64'(bus.inst_out), 64'(mem_word(64'h200)));

      // Misaligned redirect target
      redirect_to(64'h202);
      check("mis_fault_early", 64'(bus.fault_out), 64'd0);
      check("mis_flush", 64'(bus.queue_count_out), 64'd0);
      tick();
      check("mis_fault", 64'(bus.fault_out), 64'd1);
      check("mis_addr", bus.imem_address_out, 64'h202);
      tick();
      check("mis_no_push", 64'(bus.queue_count_out), 64'd0);
      redirect_to(64'h40);
      check("recover_fault", 64'(bus.fault_out), 64'd0);
      check("recover_addr", bus.imem_address_out, 64'h40);
      tick();
      check("recover_pc", bus.inst_pc_out, 64'h40);
      check("recover_inst", 64'(bus.inst_out), 64'(mem_word(64'h40)));

      // Sequential fetch runs off the end of memory; earlier entries drain
      redirect_to(64'hFF4);
      repeat (4) tick();
      check("oob_fault", 64'(bus.fault_out), 64'd1);
      check("oob_count", 64'(bus.queue_count_out), 64'd3);
      check("oob_addr", bus.imem_address_out, 64'h1000);
      tick();
      check("oob_no_push", 64'(bus.queue_count_out), 64'd3);
      bus.inst_ready_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("oob_drain_pc", bus.inst_pc_out, 64'(32'hFF4 + 4 * i));
         tick();
      end
      check("oob_empty", 64'(bus.queue_count_out), 64'd0);
      check("oob_empty_valid", 64'(bus.inst_valid_out), 64'd0);
      check("oob_fault_hold", 64'(bus.fault_out), 64'd1);

      // Redirect out of FAULT to another illegal PC re-enters FAULT
      bus.inst_ready_in = 1'b0;
      redirect_to(64'h2000);
      check("reenter_clear", 64'(bus.fault_out), 64'd0);
      tick();
      check("reenter_fault", 64'(bus.fault_out), 64'd1);
      check("reenter_count", 64'(bus.queue_count_out), 64'd0);
      redirect_to(64'h40);
      check("reenter_recover", 64'(bus.fault_out), 64'd0);

      // Asynchronous reset mid-stream
      tick();
      tick();
      check("pre_rst_count", 64'(bus.queue_count_out), 64'd2);
      rst_n_in = 1'b0;
      #2;
      check("arst_valid", 64'(bus.inst_valid_out), 64'd0);
      check("arst_count", 64'(bus.queue_count_out), 64'd0);
      check("arst_inst", 64'(bus.inst_out), 64'd0);
      check("arst_inst_pc", bus.inst_pc_out, 64'd0);
      check("arst_addr", bus.imem_address_out, 64'd0);
      tick();
      bus.inst_ready_in = 1'b1;
      rst_n_in          = 1'b1;
      tick();
      check("restart_valid", 64'(bus.inst_valid_out), 64'd1);
      check("restart_pc", bus.inst_pc_out, 64'd0);
      check("restart_inst", 64'(bus.inst_out), 64'(mem_word(64'd0)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Front-end fetch stage directly upstream of InstMemory.
- Owns the program counter and drives InstMemory's address_in every cycle. It captures the combinational data_out in the same cycle.
- Buffers {pc, instruction} pairs in a small FIFO, handed to decode via a valid/ready handshake.
- Handles control-flow redirects (queue flush) and a fault state for misaligned or out-of-range PCs.

Parameters:
- ADDR_WIDTH, 64, PC / memory address width.
- DATA_WIDTH, 32, instruction width.
- MEM_DEPTH_POW, 10, log2 of InstMemory depth in words; legal byte addresses are 0 .. (4<<MEM_DEPTH_POW)-1.
- QUEUE_DEPTH_POW, 2, log2 of fetch queue entries (default 4).
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- imem_address_out  output  ADDR_WIDTH  address to InstMemory.address_in.
- imem_data_in  input  DATA_WIDTH  InstMemory.data_out (same-cycle combinational).
- redirect_valid_in  input  1  branch/jump redirect request.
- redirect_pc_in  input  ADDR_WIDTH  redirect target.
- inst_valid_out  output  1  queue head valid.
- inst_ready_in  input  1  decode accepts head.
- inst_out  output  DATA_WIDTH  head instruction.
- inst_pc_out  output  ADDR_WIDTH  PC of head instruction.
- queue_count_out  output  QUEUE_DEPTH_POW+1  occupied entries.
- fault_out  output  1  fetch halted on illegal PC.

Behaviour:
- Reset (async, rst_n_in low):
  - pc = RESET_PC; queue empty.
  - inst_valid_out = 0, queue_count_out = 0, fault_out = 0; state = RUN.
  - inst_out and inst_pc_out = 0 while empty.
  - Reset mid-operation discards all queued entries immediately.
- imem_address_out = pc at all times.
- pop = inst_valid_out & inst_ready_in.
- inst_valid_out = (count != 0). Head is presented from queue storage; there is no combinational path from imem_data_in to inst_out.
- space = (count < 2^QUEUE_DEPTH_POW) | pop. A full queue still accepts a push in a cycle where it also pops.
- pc_legal = (pc[1:0] == 0) & (pc < 4<<MEM_DEPTH_POW).
- State RUN, one of the following each cycle, in priority order:
  - redirect_valid_in: flush the queue (count becomes 0 next cycle; any pop this cycle is still accepted but its effect is superseded). No push. Set pc = redirect_pc_in.
  - else if !pc_legal: enter FAULT; no push; pc held.
  - else if space: push {pc, imem_data_in}; pc = pc + 4.
  - else: hold pc, no push (stall).
- State FAULT:
  - fault_out = 1 (registered; asserted the cycle after entry).
  - No pushes. Existing entries continue to drain through pop.
  - redirect_valid_in: flush the queue, set pc = redirect_pc_in, return to RUN, fault_out = 0 next cycle. If the new pc is also illegal, FAULT is re-entered one cycle later.
- Latency: an instruction fetched in cycle N is visible on inst_out in cycle N+1 at the earliest. Sustained throughput is 1 instruction/cycle when decode is always ready.
- pc + 4 is computed modulo 2^ADDR_WIDTH. The range check traps before any wrap can be fetched.
- Count updates: push only +1; pop only -1; push and pop together, unchanged; flush sets 0 regardless of push or pop.
- FIFO pointers wrap modulo 2^QUEUE_DEPTH_POW.
- Queue never overflows or underflows. The bench asserts count <= depth and that no pop occurs while empty.

Test Plan:
- Reset release, imem_data_in = mem[pc/4], inst_ready_in = 1 -> cycle 1: inst_valid_out = 1, inst_pc_out = 0, inst_out = mem[0]; following cycles show pc 4, 8, 12 back-to-back.
- inst_ready_in = 0 for 8 cycles -> queue_count_out saturates at 4, imem_address_out holds at 0x10. Ready = 1 -> pcs 0x0, 0x4, 0x8, 0xC then 0x10 with no gap or duplicate.
- Full queue, then ready = 1 with continuous fetch -> count stays 4 (simultaneous push/pop), one instruction delivered per cycle.
- Redirect to 0x200 while count = 3 -> next cycle count = 0, inst_valid_out = 0. Following cycle inst_pc_out = 0x200, inst_out = mem[0x80].
- Redirect to 0x202 (misaligned), or sequential fetch reaching 0x1000 with MEM_DEPTH_POW = 10 -> fault_out = 1, no new entries, prior entries drain. Redirect to 0x40 -> fault_out = 0 and fetch resumes at 0x40.
- Assert rst_n_in mid-stream with count = 2 -> outputs zero asynchronously. After release, fetch restarts at RESET_PC.
